// File: rtl/counter_mbox_pkg.sv
`default_nettype none
// ============================================================================
// counter_mbox_pkg : mailbox map, command and status codes for the counter
//                    BRAM mailbox (shared by initiator and responder)
// Revision: 1.0
// ============================================================================
package counter_mbox_pkg;

  localparam logic [31:0] MBOX_CMD  = 32'h0000_0000;
  localparam logic [31:0] MBOX_EN   = 32'h0000_0004;
  localparam logic [31:0] MBOX_RST  = 32'h0000_0008;
  localparam logic [31:0] MBOX_CNT0 = 32'h0000_000C;
  localparam logic [31:0] MBOX_CNT1 = 32'h0000_0010;
  localparam logic [31:0] MBOX_CNT2 = 32'h0000_0014;

  localparam logic [1:0] CMD_EN  = 2'd1;
  localparam logic [1:0] CMD_RST = 2'd2;
  localparam logic [1:0] CMD_WRT = 2'd3;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_BADCMD  = 2'd2
  } status_t;

  // Mask register that carries the argument of an ENABLE/RESET command.
  function automatic logic [31:0] arg_addr(input logic [1:0] cmd);
    return (cmd == CMD_RST) ? MBOX_RST : MBOX_EN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_cmd_host_if.sv
`default_nettype none
// ============================================================================
// counter_cmd_host_if : request/response handshakes and BRAM port of the
//                       counter mailbox initiator
// Revision: 1.0
// ============================================================================
interface counter_cmd_host_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_cmd_i;
  logic [2:0]  req_mask_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_status_o;
  logic [31:0] rsp_cnt0_o;
  logic [31:0] rsp_cnt1_o;
  logic [31:0] rsp_cnt2_o;
  logic        busy_o;
  logic        we;
  logic [31:0] addr;
  logic [31:0] dout;
  logic [31:0] din;

  modport master (
    input  req_valid_i, req_cmd_i, req_mask_i, rsp_ready_i, din,
    output req_ready_o, rsp_valid_o, rsp_status_o,
           rsp_cnt0_o, rsp_cnt1_o, rsp_cnt2_o, busy_o, we, addr, dout
  );

  modport slave (
    output req_valid_i, req_cmd_i, req_mask_i, rsp_ready_i, din,
    input  req_ready_o, rsp_valid_o, rsp_status_o,
           rsp_cnt0_o, rsp_cnt1_o, rsp_cnt2_o, busy_o, we, addr, dout
  );

endinterface
`default_nettype wire

// File: rtl/mbox_rd_wait.sv
`default_nettype none
// ============================================================================
// mbox_rd_wait : counts BRAM read latency after a read is issued and flags
//                when din carries the addressed word
// Revision: 1.0
// ============================================================================
module mbox_rd_wait #(
  parameter int RD_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  output logic strobe
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic [1:0] cnt_q;

  // Saturates at LAT: with a static address the BRAM refreshes din every
  // cycle, so the strobe stays high for back-to-back polling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= 2'd0;
    else if (start)
      cnt_q <= 2'd0;
    else if (cnt_q != LAT)
      cnt_q <= cnt_q + 2'd1;
  end

  assign strobe = (cnt_q == LAT);

endmodule
`default_nettype wire

// File: rtl/counter_cmd_host.sv
`default_nettype none
// ============================================================================
// counter_cmd_host : initiator side of the counter-management BRAM mailbox
// Revision: 1.0
// ============================================================================
module counter_cmd_host
  import counter_mbox_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic               clk_i,
  input  logic               rst_i,
  counter_cmd_host_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WR_ARG = 4'd1,
    WR_CMD = 4'd2,
    POLL   = 4'd3,
    ABORT  = 4'd4,
    RD_C0  = 4'd5,
    RD_C1  = 4'd6,
    RD_C2  = 4'd7,
    RESP   = 4'd8
  } state_t;

  state_t           state_q, state_n;
  logic [1:0]       cmd_q, cmd_n;
  logic [2:0]       mask_q, mask_n;
  logic [CNT_W-1:0] tcnt_q, tcnt_n;
  status_t          status_q, status_n;
  logic [31:0]      cnt0_q, cnt0_n, cnt1_q, cnt1_n, cnt2_q, cnt2_n;
  logic             we_q, we_n;
  logic [31:0]      addr_q, addr_n, dout_q, dout_n;
  logic             rsp_valid_q, busy_q, req_ready_q;
  logic             rd_start, rd_strobe;

  // Every state change issues a new read (or write), so the latency count restarts.
  assign rd_start = (state_n != state_q);

  mbox_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (rd_start),
    .strobe (rd_strobe)
  );

  always_comb begin
    state_n  = state_q;
    cmd_n    = cmd_q;
    mask_n   = mask_q;
    tcnt_n   = tcnt_q;
    status_n = status_q;
    cnt0_n   = cnt0_q;
    cnt1_n   = cnt1_q;
    cnt2_n   = cnt2_q;
    case (state_q)
      IDLE: if (bus.req_valid_i) begin
        cmd_n  = bus.req_cmd_i;
        mask_n = bus.req_mask_i;
        if (bus.req_cmd_i == 2'd0) begin
          state_n  = RESP;
          status_n = ST_BADCMD;
        end else if (bus.req_cmd_i == CMD_WRT) begin
          state_n = WR_CMD;
        end else begin
          state_n = WR_ARG;
        end
      end
      WR_ARG: state_n = WR_CMD;
      WR_CMD: begin
        state_n = POLL;
        tcnt_n  = '0;
      end
      POLL: begin
        tcnt_n = tcnt_q + 1'b1;
        // A clear seen on the expiry cycle still counts as success.
        if (rd_strobe && (bus.din == 32'h0)) begin
          if (cmd_q == CMD_WRT) begin
            state_n = RD_C0;
          end else begin
            state_n  = RESP;
            status_n = ST_OK;
          end
        end else if (tcnt_n == CNT_W'(TIMEOUT)) begin
          state_n = ABORT;
        end
      end
      ABORT: begin
        state_n  = RESP;
        status_n = ST_TIMEOUT;
      end
      RD_C0: if (rd_strobe) begin
        cnt0_n  = bus.din;
        state_n = RD_C1;
      end
      RD_C1: if (rd_strobe) begin
        cnt1_n  = bus.din;
        state_n = RD_C2;
      end
      RD_C2: if (rd_strobe) begin
        cnt2_n   = bus.din;
        state_n  = RESP;
        status_n = ST_OK;
      end
      RESP: if (bus.rsp_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with it.
    we_n   = (state_n == WR_ARG) || (state_n == WR_CMD) || (state_n == ABORT);
    addr_n = MBOX_CMD;
    dout_n = 32'h0;
    case (state_n)
      WR_ARG: begin
        addr_n = arg_addr(cmd_n);
        dout_n = {29'h0, mask_n};
      end
      WR_CMD: dout_n = {30'h0, cmd_n};
      RD_C0:  addr_n = MBOX_CNT0;
      RD_C1:  addr_n = MBOX_CNT1;
      RD_C2:  addr_n = MBOX_CNT2;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= 2'd0;
      mask_q      <= 3'd0;
      tcnt_q      <= '0;
      status_q    <= ST_OK;
      cnt0_q      <= 32'h0;
      cnt1_q      <= 32'h0;
      cnt2_q      <= 32'h0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      dout_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_n;
      cmd_q       <= cmd_n;
      mask_q      <= mask_n;
      tcnt_q      <= tcnt_n;
      status_q    <= status_n;
      cnt0_q      <= cnt0_n;
      cnt1_q      <= cnt1_n;
      cnt2_q      <= cnt2_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      dout_q      <= dout_n;
      rsp_valid_q <= (state_n == RESP);
      busy_q      <= (state_n != IDLE) && (state_n != RESP);
      req_ready_q <= (state_n == IDLE);
    end
  end

  assign bus.we           = we_q;
  assign bus.addr         = addr_q;
  assign bus.dout         = dout_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_status_o = status_q;
  assign bus.rsp_cnt0_o   = cnt0_q;
  assign bus.rsp_cnt1_o   = cnt1_q;
  assign bus.rsp_cnt2_o   = cnt2_q;
  assign bus.busy_o       = busy_q;
  assign bus.req_ready_o  = req_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_host.sv
`default_nettype none
// ============================================================================
// tb_counter_cmd_host : counter_cmd_host against a BRAM + responder model
// Revision: 1.0
// ============================================================================
module tb_counter_cmd_host;
  import counter_mbox_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  counter_cmd_host_if bus();

  counter_cmd_host #(.RD_LAT(1), .TIMEOUT(TO), .CNT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Mailbox memory and management responder
  logic [31:0] mem [0:7] = '{default: 32'h0};
  logic [31:0] ctr [0:2] = '{default: 32'h0};
  logic [31:0] ld_val [0:2];
  int          ld_seq = 0;
  int          ld_seen = 0;
  logic [2:0]  en_cnt = 3'b000;
  logic        resp_on = 1'b1;
  int          resp_delay = 0;
  int          resp_wait = 0;
  int          cyc = 0;
  logic [63:0] wlog [$];
  int          wcyc [$];

  always @(posedge clk) begin
    bus.din <= mem[bus.addr[4:2]];
    if (ld_seq != ld_seen) begin
      for (int i = 0; i < 3; i++) ctr[i] = ld_val[i];
      ld_seen = ld_seq;
    end
    if (resp_on && mem[0] != 32'h0) begin
      if (resp_wait < resp_delay) begin
        resp_wait++;
      end else begin
        case (mem[0][1:0])
          2'd1: en_cnt = en_cnt | mem[1][2:0];
          2'd2: for (int i = 0; i < 3; i++) if (mem[2][i]) ctr[i] = 32'h0;
          2'd3: for (int i = 0; i < 3; i++) mem[3+i] = ctr[i];
          default: ;
        endcase
        mem[0]    = 32'h0;
        resp_wait = 0;
      end
    end else begin
      resp_wait = 0;
    end
    if (bus.we) begin
      mem[bus.addr[4:2]] = bus.dout;
      wlog.push_back({bus.addr, bus.dout});
      wcyc.push_back(cyc);
    end
    cyc++;
  end

  logic [31:0] exp_cnt [0:2] = '{default: 32'h0};
  logic [2:0]  exp_en = 3'b000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ctr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ld_val[0] = a;
    ld_val[1] = b;
    ld_val[2] = c;
    ld_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_txn(input logic [1:0] cmd, input logic [2:0] mask, input logic on,
                        input int dly, input int hold);
    logic [63:0] exp_w [$];
    logic [1:0]  exp_st;
    int          base;
    int          n;
    resp_on    = on;
    resp_delay = dly;
    if (cmd == 2'd0) begin
      exp_st = 2'd2;
    end else begin
      if (cmd != 2'd3) exp_w.push_back({(cmd == 2'd1) ? 32'h4 : 32'h8, 29'h0, mask});
      exp_w.push_back({32'h0, 30'h0, cmd});
      if (on) begin
        exp_st = 2'd0;
        if (cmd == 2'd3) for (int i = 0; i < 3; i++) exp_cnt[i] = ctr[i];
        if (cmd == 2'd1) exp_en = exp_en | mask;
      end else begin
        exp_w.push_back(64'h0);
        exp_st = 2'd1;
      end
    end
    base = wlog.size();

    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_cmd_i   = cmd;
    bus.req_mask_i  = mask;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin @(negedge clk); n++; end
    check("req_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;

    n = 0;
    while (!bus.rsp_valid_o && n < 200) begin @(negedge clk); n++; end
    check("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    if (cmd == 2'd0) check("badcmd_latency", 64'(n <= 2), 64'd1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check("rsp_hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("rsp_status", 64'(bus.rsp_status_o), 64'(exp_st));
      check("rsp_cnt0", 64'(bus.rsp_cnt0_o), 64'(exp_cnt[0]));
      check("rsp_cnt1", 64'(bus.rsp_cnt1_o), 64'(exp_cnt[1]));
      check("rsp_cnt2", 64'(bus.rsp_cnt2_o), 64'(exp_cnt[2]));
      check("busy_in_resp", 64'(bus.busy_o), 64'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    check("rsp_drop", 64'(bus.rsp_valid_o), 64'd0);
    check("req_ready_idle", 64'(bus.req_ready_o), 64'd1);

    check("write_count", 64'(wlog.size() - base), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++)
      if (base + k < wlog.size()) check("write_addr_data", wlog[base+k], exp_w[k]);
    if (cmd != 2'd0 && !on && (wlog.size() - base) >= 2)
      check("timeout_gap", 64'(wcyc[$] - wcyc[$-1]), 64'(TO + 1));
    check("responder_enables", 64'(en_cnt), 64'(exp_en));
  endtask

  logic [1:0] rc;
  logic [2:0] rm;
  logic       ron;

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_cmd_i   = 2'd0;
    bus.req_mask_i  = 3'd0;
    bus.rsp_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_we", 64'(bus.we), 64'd0);
    check("rst_addr", 64'(bus.addr), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_status", 64'(bus.rsp_status_o), 64'd0);
    check("rst_cnt0", 64'(bus.rsp_cnt0_o), 64'd0);
    check("rst_cnt1", 64'(bus.rsp_cnt1_o), 64'd0);
    check("rst_cnt2", 64'(bus.rsp_cnt2_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    do_txn(CMD_EN, 3'b101, 1'b1, 2, 0);
    load_ctr(32'h11, 32'h2222, 32'hDEADBEEF);
    do_txn(CMD_WRT, 3'b000, 1'b1, 1, 0);
    do_txn(CMD_RST, 3'b010, 1'b1, 0, 0);
    do_txn(CMD_WRT, 3'b000, 1'b0, 0, 0);
    do_txn(2'd0, 3'b111, 1'b1, 0, 5);

    // Reset while a SNAPSHOT is still polling
    load_ctr(32'h1, 32'h2, 32'h3);
    resp_on = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_cmd_i   = CMD_WRT;
    check("poll_req_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("poll_busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_we", 64'(bus.we), 64'd0);
    check("arst_busy", 64'(bus.busy_o), 64'd0);
    check("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("arst_no_cleanup", 64'(mem[0]), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 32'h0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("post_rst_cnt0", 64'(bus.rsp_cnt0_o), 64'd0);
    resp_on = 1'b1;
    repeat (5) @(negedge clk);
    do_txn(CMD_EN, 3'b011, 1'b1, 3, 1);

    for (int t = 0; t < 24; t++) begin
      rc  = 2'($urandom_range(0, 3));
      rm  = 3'($urandom);
      ron = ($urandom_range(0, 4) != 0);
      if (rc == CMD_WRT) load_ctr($urandom, $urandom, $urandom);
      do_txn(rc, rm, ron, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_cmd_host.md
Name: counter_cmd_host

Overview:
- Initiator side of the counter-management BRAM mailbox.
- Accepts a command request on a valid/ready handshake from fabric logic.
- Writes the argument word and then the command word into the shared BRAM.
- Polls the command register until the management responder clears it.
- For the read-back command, fetches the three counter snapshots and returns them with a status on a valid/ready response handshake.

Parameters:
- RD_LAT, 1: BRAM read latency in cycles, from addr presented to din valid; legal range 1..3.
- TIMEOUT, 4096: max cycles from the command write to the observed clear before abort.
- CNT_W, 13: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_cmd_i  in  2  1=ENABLE, 2=RESET, 3=SNAPSHOT; 0 is illegal.
- req_mask_i  in  3  per-counter bit mask for ENABLE/RESET; ignored for SNAPSHOT.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_status_o  out  2  0=OK, 1=TIMEOUT, 2=BADCMD.
- rsp_cnt0_o  out  32  counter 0 snapshot (mailbox 0xC).
- rsp_cnt1_o  out  32  counter 1 snapshot (mailbox 0x10).
- rsp_cnt2_o  out  32  counter 2 snapshot (mailbox 0x14).
- busy_o  out  1  high in every state except IDLE and RESP.
- we  out  1  BRAM write enable.
- addr  out  32  BRAM byte address.
- dout  out  32  BRAM write data.
- din  in  32  BRAM read data.

Behaviour:
- Reset values: we=0, addr=0, dout=0, rsp_valid_o=0, rsp_status_o=0, all rsp_cnt*_o=0, busy_o=0, req_ready_o=1, state=IDLE, timeout counter=0.
- Reset mid-operation aborts immediately. No cleanup write is issued; the responder-side command word stays as last written.
- Mailbox map (byte addresses): 0x0 command, 0x4 enable mask, 0x8 reset mask, 0xC/0x10/0x14 counter 0/1/2.
- All bus outputs are registered. we is high for exactly one cycle per write.
- States and transitions:
  - IDLE: req_ready_o=1, we=0, addr=0. On req_valid_i, latch cmd and mask.
    - cmd=0 goes to RESP with BADCMD and no bus activity.
    - cmd=1 or 2 goes to WR_ARG.
    - cmd=3 goes to WR_CMD.
  - WR_ARG: we=1, addr=0x4 (ENABLE) or 0x8 (RESET), dout={29'b0,mask}. Next: WR_CMD.
  - WR_CMD: we=1, addr=0x0, dout={30'b0,cmd}. Clear the timeout counter. Next: POLL.
  - POLL: we=0, addr=0x0. Wait RD_LAT cycles, then sample din.
    - din==0: go to RD_C0 for SNAPSHOT, otherwise RESP with OK.
    - din!=0: re-issue the poll read (back-to-back polling).
  - Timeout counter: increments every cycle from WR_CMD+1 while in POLL. When it reaches TIMEOUT, go to ABORT. A clear sampled in the same cycle as expiry wins (OK).
  - ABORT: we=1, addr=0x0, dout=0 (cancel the command). Next: RESP with TIMEOUT; snapshot outputs keep their previous values.
  - RD_C0 / RD_C1 / RD_C2: addr=0xC / 0x10 / 0x14, we=0. Capture din into rsp_cnt0/1/2_o after RD_LAT cycles. RD_C2 goes to RESP with OK.
  - RESP: rsp_valid_o=1; data and status are held stable. Return to IDLE on rsp_ready_i. rsp_valid_o drops the cycle after acceptance.
- Latency with RD_LAT=1 and an instant responder:
  - ENABLE/RESET: request accept to rsp_valid_o is 4 cycles minimum.
  - SNAPSHOT: adds 2*3 cycles of reads.
- The responder services SNAPSHOT over three passes before clearing 0x0. TIMEOUT must exceed roughly 3 × (responder loop + RD_LAT); the default covers this.
- rsp_cnt*_o are updated only by a successful SNAPSHOT. ENABLE/RESET leave them unchanged.
- req_valid_i while not IDLE is ignored (req_ready_o=0). The request must be held until accepted.

Decomposition:
- Shared package counter_mbox_pkg:
  - address constants MBOX_CMD=0x0, MBOX_EN=0x4, MBOX_RST=0x8, MBOX_CNT0=0xC, MBOX_CNT1=0x10, MBOX_CNT2=0x14;
  - command codes CMD_EN=1, CMD_RST=2, CMD_WRT=3;
  - status codes;
  - the responder is to import the same constants.
- One natural sub-module: mbox_rd_wait, a small RD_LAT delay counter that produces a din-valid strobe, reused by POLL and the RD_C* states.

Test Plan:
- ENABLE, mask=3'b101, with a BRAM model and responder model → one write 0x4=0x5, then 0x0=0x1; polls until 0x0==0; rsp OK; responder enables counters 0 and 2.
- RESET, mask=3'b010 → writes 0x8=0x2, then 0x0=0x2; status OK; rsp_cnt*_o unchanged.
- SNAPSHOT with counters preloaded 0x11, 0x2222, 0xDEADBEEF → reads 0xC/0x10/0x14 after the clear; rsp_cnt0/1/2_o equal those values; status OK.
- Responder disabled, TIMEOUT=16 → after 16 poll cycles, writes 0x0=0 and returns status TIMEOUT; snapshots unchanged.
- req_cmd_i=0 → no we pulse, rsp_status_o=BADCMD within 2 cycles. Hold rsp_ready_i low for 5 cycles → rsp_valid_o and data stay stable throughout.
- Assert rst_i during POLL of a SNAPSHOT → same cycle: we=0, busy_o=0, rsp_valid_o=0; req_ready_o=1 after reset release; a fresh ENABLE then completes OK.
